// File: rtl/panda_mem_arbiter.sv
// Arbiter that shares one single-port synchronous RAM between the Panda core's fetch and data ports.
// Data accesses win by default; a contested-grant streak counter forces fetch through at STARVE_LIMIT.
module panda_mem_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        instr_req_i,
   input  logic [31:0] instr_addr_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   output logic [31:0] instr_rdata_o,
   input  logic        data_req_i,
   input  logic [31:0] data_addr_i,
   input  logic [3:0]  data_we_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   output logic [3:0]  mem_we_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      OWN_NONE  = 2'd0,
      OWN_INSTR = 2'd1,
      OWN_DATA  = 2'd2
   } owner_e;

   owner_e        r_owner;
   owner_e        w_owner_nxt;
   logic [SW-1:0] r_streak;
   logic [SW-1:0] w_streak_nxt;
   logic          w_contested;
   logic          w_instr_win;
   logic          w_data_win;

   // Handshake: a requester holds req and payload stable until it sees gnt in the same
   // cycle; the matching rvalid (with rdata) arrives exactly one cycle after that gnt.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_owner  <= OWN_NONE;
         r_streak <= '0;
      end else begin
         r_owner  <= w_owner_nxt;
         r_streak <= w_streak_nxt;
      end
   end

   always_comb begin
      w_contested  = instr_req_i & data_req_i;
      w_instr_win  = instr_req_i & (~data_req_i | (r_streak == LIMIT));
      w_data_win   = data_req_i & ~w_instr_win;
      w_owner_nxt  = OWN_NONE;
      w_streak_nxt = r_streak;
      if (w_instr_win) begin
         w_owner_nxt  = OWN_INSTR;
         w_streak_nxt = '0;
      end else if (w_data_win) begin
         w_owner_nxt = OWN_DATA;
         // Only a data win over a waiting fetch counts toward starvation.
         if (w_contested) begin
            w_streak_nxt = r_streak + 1'b1;
         end
      end
   end

   always_comb begin
      instr_gnt_o = w_instr_win;
      data_gnt_o  = w_data_win;
      mem_req_o   = 1'b0;
      mem_addr_o  = '0;
      mem_we_o    = '0;
      mem_wdata_o = '0;
      if (w_instr_win) begin
         mem_req_o  = 1'b1;
         mem_addr_o = instr_addr_i;
      end else if (w_data_win) begin
         mem_req_o   = 1'b1;
         mem_addr_o  = data_addr_i;
         mem_we_o    = data_we_i;
         mem_wdata_o = data_wdata_i;
      end
   end

   assign instr_rvalid_o = (r_owner == OWN_INSTR);
   assign data_rvalid_o  = (r_owner == OWN_DATA);
   assign instr_rdata_o  = mem_rdata_i;
   assign data_rdata_o   = mem_rdata_i;

endmodule

// File: tb/tb_panda_mem_arbiter.sv
// Bench for panda_mem_arbiter: per-cycle comparison against a rule-level model, directed
// scenarios with literal grant sequences, then randomized traffic with occasional resets.
module tb_panda_mem_arbiter;

   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        instr_req_i = 1'b0;
   logic [31:0] instr_addr_i = '0;
   logic        instr_gnt_o;
   logic        instr_rvalid_o;
   logic [31:0] instr_rdata_o;
   logic        data_req_i = 1'b0;
   logic [31:0] data_addr_i = '0;
   logic [3:0]  data_we_i = '0;
   logic [31:0] data_wdata_i = '0;
   logic        data_gnt_o;
   logic        data_rvalid_o;
   logic [31:0] data_rdata_o;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic [3:0]  mem_we_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] mem_rdata_i = '0;

   int total = 0;
   int bad = 0;

   // model: who was granted last cycle (0 none, 1 instr, 2 data) and the contested streak
   int m_owner = 0;
   int m_streak = 0;
   int n_owner = 0;
   int n_streak = 0;

   bit    log_en = 1'b0;
   string g_log = "";

   panda_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .instr_req_i    (instr_req_i),
      .instr_addr_i   (instr_addr_i),
      .instr_gnt_o    (instr_gnt_o),
      .instr_rvalid_o (instr_rvalid_o),
      .instr_rdata_o  (instr_rdata_o),
      .data_req_i     (data_req_i),
      .data_addr_i    (data_addr_i),
      .data_we_i      (data_we_i),
      .data_wdata_i   (data_wdata_i),
      .data_gnt_o     (data_gnt_o),
      .data_rvalid_o  (data_rvalid_o),
      .data_rdata_o   (data_rdata_o),
      .mem_req_o      (mem_req_o),
      .mem_addr_o     (mem_addr_o),
      .mem_we_o       (mem_we_o),
      .mem_wdata_o    (mem_wdata_o),
      .mem_rdata_i    (mem_rdata_i)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_str(input string name, input string act, input string exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %s expected %s", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_owner  <= 0;
         m_streak <= 0;
      end else begin
         m_owner  <= n_owner;
         m_streak <= n_streak;
      end
   end

   // compare process: outputs settle mid-cycle, inputs only change just after posedge
   always @(negedge clk) begin
      int g;
      logic [31:0] e_addr;
      logic [31:0] e_wdata;
      logic [3:0]  e_we;
      if (instr_req_i && !data_req_i)      g = 1;
      else if (!instr_req_i && data_req_i) g = 2;
      else if (instr_req_i && data_req_i)  g = (m_streak >= LIMIT) ? 1 : 2;
      else                                 g = 0;
      e_addr  = (g == 1) ? instr_addr_i : (g == 2) ? data_addr_i : 32'h0;
      e_we    = (g == 2) ? data_we_i : 4'h0;
      e_wdata = (g == 2) ? data_wdata_i : 32'h0;
      check("instr_gnt", {31'b0, instr_gnt_o}, {31'b0, g == 1});
      check("data_gnt", {31'b0, data_gnt_o}, {31'b0, g == 2});
      check("mem_req", {31'b0, mem_req_o}, {31'b0, g != 0});
      check("mem_addr", mem_addr_o, e_addr);
      check("mem_we", {28'b0, mem_we_o}, {28'b0, e_we});
      check("mem_wdata", mem_wdata_o, e_wdata);
      check("instr_rvalid", {31'b0, instr_rvalid_o}, {31'b0, m_owner == 1});
      check("data_rvalid", {31'b0, data_rvalid_o}, {31'b0, m_owner == 2});
      check("instr_rdata", instr_rdata_o, mem_rdata_i);
      check("data_rdata", data_rdata_o, mem_rdata_i);
      n_owner  <= g;
      n_streak <= (g == 1) ? 0 : (g == 2 && instr_req_i) ? m_streak + 1 : m_streak;
      if (log_en) g_log = {g_log, instr_gnt_o ? "I" : data_gnt_o ? "D" : "-"};
   end

   task automatic set_both(input logic ireq, input logic dreq);
      instr_req_i = ireq;
      data_req_i  = dreq;
   endtask

   initial begin
      // reset with both requesters active
      #1;
      rst = 1'b1;
      instr_addr_i = 32'h0000_0100;
      data_addr_i  = 32'h0000_0A00;
      set_both(1'b1, 1'b1);
      #1;
      check("rst_instr_rvalid", {31'b0, instr_rvalid_o}, 32'h0);
      check("rst_data_rvalid", {31'b0, data_rvalid_o}, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_first_dgnt", {31'b0, data_gnt_o}, 32'h1);
      check("rst_first_addr", mem_addr_o, 32'h0000_0A00);

      // instruction-only fetch
      step();
      set_both(1'b1, 1'b0);
      instr_addr_i = 32'h0000_0100;
      @(negedge clk);
      check("if_gnt", {31'b0, instr_gnt_o}, 32'h1);
      check("if_we", {28'b0, mem_we_o}, 32'h0);
      step();
      set_both(1'b0, 1'b0);
      mem_rdata_i = 32'hDEAD_BEEF;
      @(negedge clk);
      check("if_rvalid", {31'b0, instr_rvalid_o}, 32'h1);
      check("if_rdata", instr_rdata_o, 32'hDEAD_BEEF);
      check("if_no_drvalid", {31'b0, data_rvalid_o}, 32'h0);

      // data write
      step();
      set_both(1'b0, 1'b1);
      data_addr_i  = 32'h0000_0204;
      data_we_i    = 4'b0011;
      data_wdata_i = 32'h1234_5678;
      @(negedge clk);
      check("dw_addr", mem_addr_o, 32'h0000_0204);
      check("dw_we", {28'b0, mem_we_o}, 32'h3);
      check("dw_wdata", mem_wdata_o, 32'h1234_5678);
      step();
      set_both(1'b0, 1'b0);
      data_we_i = 4'h0;
      @(negedge clk);
      check("dw_rvalid", {31'b0, data_rvalid_o}, 32'h1);

      // starvation guard
      step();
      set_both(1'b1, 1'b1);
      g_log = "";
      log_en = 1'b1;
      repeat (10) @(negedge clk);
      step();
      log_en = 1'b0;
      check_str("starve_seq", g_log, "DDDDIDDDDI");

      // data-only cycles keep the streak
      g_log = "";
      log_en = 1'b1;
      repeat (3) @(negedge clk);
      step();
      set_both(1'b0, 1'b1);
      repeat (2) @(negedge clk);
      step();
      set_both(1'b1, 1'b1);
      repeat (2) @(negedge clk);
      step();
      log_en = 1'b0;
      set_both(1'b0, 1'b0);
      check_str("streak_hold_seq", g_log, "DDDDDDI");

      // reset while a fetch response is pending
      step();
      set_both(1'b1, 1'b0);
      instr_addr_i = 32'h0000_0300;
      @(negedge clk);
      check("mid_if_gnt", {31'b0, instr_gnt_o}, 32'h1);
      #2 rst = 1'b1;
      step();
      check("mid_if_rvalid", {31'b0, instr_rvalid_o}, 32'h0);
      set_both(1'b0, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_irv", {31'b0, instr_rvalid_o}, 32'h0);
      check("post_rst_drv", {31'b0, data_rvalid_o}, 32'h0);

      // reset mid-streak must clear it
      step();
      set_both(1'b1, 1'b1);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      step();
      check("mid_d_rvalid", {31'b0, data_rvalid_o}, 32'h0);
      rst = 1'b0;
      g_log = "";
      log_en = 1'b1;
      repeat (5) @(negedge clk);
      step();
      log_en = 1'b0;
      check_str("streak_cleared_seq", g_log, "DDDDI");

      // asynchronous clear of a live response
      set_both(1'b0, 1'b1);
      step();
      set_both(1'b0, 1'b0);
      check("async_pre_rv", {31'b0, data_rvalid_o}, 32'h1);
      #2 rst = 1'b1;
      #1;
      check("async_rv", {31'b0, data_rvalid_o}, 32'h0);
      step();
      rst = 1'b0;

      // randomized traffic honouring hold-until-granted
      for (int i = 0; i < 3000; i++) begin
         step();
         if (rst) rst = 1'b0;
         if (!instr_req_i || m_owner == 1) begin
            instr_req_i  = ($urandom_range(0, 2) != 0);
            instr_addr_i = $urandom;
         end
         if (!data_req_i || m_owner == 2) begin
            data_req_i   = ($urandom_range(0, 3) != 0);
            data_addr_i  = $urandom;
            data_we_i    = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
            data_wdata_i = $urandom;
         end
         mem_rdata_i = $urandom;
         if ($urandom_range(0, 199) == 0) rst = 1'b1;
      end
      step();
      rst = 1'b0;
      set_both(1'b0, 1'b0);
      repeat (2) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/panda_mem_arbiter.md
# panda_mem_arbiter

Shares one single-port synchronous memory between the Panda core's instruction-fetch port and data-access port. Each cycle it grants at most one requester, drives that requester's access onto the memory, and routes the memory's one-cycle-later response back to it. Data accesses have priority, and a bounded streak counter keeps instruction fetch from starving. The block sits between the core's fetch/load-store ports and a unified instruction/data RAM.

## Interface
Parameters:
- STARVE_LIMIT, 4, max consecutive contested data grants before instruction fetch is forced through; legal range 1..15

Ports:
- clk_i  in  1  clock, all state updates on the rising edge
- rst_i  in  1  asynchronous, active-high reset
- instr_req_i  in  1  fetch request, held until granted
- instr_addr_i  in  32  fetch byte address
- instr_gnt_o  out  1  fetch accepted this cycle (combinational)
- instr_rvalid_o  out  1  fetch response valid (registered)
- instr_rdata_o  out  32  fetch response data
- data_req_i  in  1  data request, held until granted
- data_addr_i  in  32  data byte address
- data_we_i  in  4  byte write enables; 0 means read
- data_wdata_i  in  32  write data
- data_gnt_o  out  1  data accepted this cycle (combinational)
- data_rvalid_o  out  1  data response valid (registered); pulses for reads and writes
- data_rdata_o  out  32  data response data; don't-care for writes
- mem_req_o  out  1  memory access this cycle
- mem_addr_o  out  32  memory address
- mem_we_o  out  4  memory byte enables
- mem_wdata_o  out  32  memory write data
- mem_rdata_i  in  32  memory read data, valid the cycle after mem_req_o

## Operation
- State consists of `owner` (NONE/INSTR/DATA, 2 bits), the owner of the access issued last cycle, and `streak`, a counter of width $clog2(STARVE_LIMIT+1).
- Arbitration is combinational and evaluated every cycle:
  - Only instr_req_i asserted: grant INSTR; streak <= 0.
  - Only data_req_i asserted: grant DATA; streak unchanged.
  - Both asserted (contested) with streak < STARVE_LIMIT: grant DATA; streak <= streak+1.
  - Both asserted with streak == STARVE_LIMIT: grant INSTR; streak <= 0.
  - Neither asserted: no grant; streak unchanged.
- Memory drive:
  - INSTR grant: mem_req_o=1, mem_addr_o=instr_addr_i, mem_we_o=0, mem_wdata_o=0.
  - DATA grant: mem_req_o=1, and addr/we/wdata are copied from the data port.
  - No grant: mem_req_o, mem_addr_o, mem_we_o and mem_wdata_o are all 0.
- owner <= granted requester, or NONE when there is no grant.
- Responses:
  - instr_rvalid_o = (owner==INSTR); data_rvalid_o = (owner==DATA).
  - instr_rdata_o = data_rdata_o = mem_rdata_i, unconditional fan-out; the rvalid signals qualify it.
- A requester not granted must keep req and payload stable. The arbiter does not latch un-granted payloads.
- The two grants are mutually exclusive, and at most one rvalid is high per cycle.

## Timing
- Reset (asynchronous assert, synchronous release): owner=NONE, streak=0. Both rvalid outputs are 0 immediately on assertion; gnt and mem outputs follow the rules above with the reset state.
- Grant latency: 0 cycles, same cycle as the request when it wins.
- Response latency: exactly 1 cycle after the grant.
- Back-to-back grants are allowed every cycle (full throughput, one access per cycle). A response and a new grant may occur in the same cycle.
- Streak boundary: with both requesting continuously, the pattern is STARVE_LIMIT data grants, then 1 instr grant, repeating. For STARVE_LIMIT=4 the period is 5 cycles.
- A data-only cycle between contested cycles does not reset streak; only an instruction grant clears it.
- Reset mid-operation: a response pending for the next cycle is dropped (no rvalid after reset), and streak is cleared.

## Test plan
- Reset check: assert rst_i with both reqs high. Required: rvalid outputs are 0 asynchronously. After release, the first cycle grants DATA (streak=0) and mem_addr_o=data_addr_i.
- Instruction only: instr_req_i=1, addr 0x100, memory returns 0xDEADBEEF. Required: instr_gnt_o=1 and mem_we_o=0 in the same cycle; next cycle instr_rvalid_o=1 with rdata 0xDEADBEEF and data_rvalid_o=0.
- Data write: data_req_i=1, addr 0x204, we=4'b0011, wdata 0x12345678. Required: mem outputs mirror the data port; data_rvalid_o=1 one cycle later.
- Starvation guard: both reqs held for 10 cycles with STARVE_LIMIT=4. Required grant sequence is D D D D I D D D D I; streak reads 0 after each I.
- Streak hold: contested for 3 cycles (D D D), then data-only for 2 cycles, then contested again. Required: DATA for one more contested cycle, then INSTR.
- Reset mid-flight: grant INSTR, assert rst_i before the next edge. Required: instr_rvalid_o stays 0 and no rvalid appears after release.
